// File: rtl/rgb_f16_frame_sequencer.sv
// Frame sequencer: reads xRGB pixel words one at a time, converts each 8-bit lane to FP16, streams 64-bit words.
// Build option: define F16_ALPHA_ONE_EN to drive the alpha lane with FP16 1.0 instead of zero.
module rgb_f16_frame_sequencer #(
  parameter int ADDR_W   = 32,
  parameter int CNT_W    = 20,
  parameter int ADDR_INC = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  pix_count,
  output logic              rd_req,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic              rd_valid,
  input  logic [31:0]       rd_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [63:0]       m_data,
  output logic              m_last,
  output logic              busy,
  output logic              done
);

`ifdef F16_ALPHA_ONE_EN
  localparam logic [15:0] ALPHA = 16'h3C00;
`else
  localparam logic [15:0] ALPHA = 16'h0000;
`endif

  typedef enum logic [2:0] {IDLE, REQ, WAIT, EMIT, DONE} state_t;

  state_t             state, state_next;
  logic [ADDR_W-1:0]  addr, addr_next;
  logic [CNT_W-1:0]   remaining, remaining_next;
  logic               m_valid_next, m_last_next, done_next;
  logic [63:0]        m_data_next;
  logic [15:0]        lane_f16 [3];

  // Exact uint8 -> FP16: every value fits in the 11-bit significand, so no rounding.
  function automatic logic [15:0] u8_to_f16(input logic [7:0] u);
    logic [3:0]  msb;
    logic [17:0] shifted;
    logic [4:0]  expo;
    msb = 4'd0;
    for (int i = 0; i < 8; i++) begin
      if (u[i]) msb = 4'(i);
    end
    shifted = {10'd0, u} << (4'd10 - msb);
    expo    = 5'd15 + {1'b0, msb};
    u8_to_f16 = (u == 8'd0) ? 16'h0000 : {1'b0, expo, shifted[9:0]};
  endfunction

  // Lane 0 = B, 1 = G, 2 = R.
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_lane
      assign lane_f16[gi] = u8_to_f16(rd_data[8*gi +: 8]);
    end
  endgenerate

  assign busy    = (state != IDLE);
  assign rd_req  = (state == REQ);
  assign rd_addr = addr;

  always_comb begin
    state_next     = state;
    addr_next      = addr;
    remaining_next = remaining;
    m_valid_next   = m_valid;
    m_last_next    = m_last;
    m_data_next    = m_data;
    done_next      = 1'b0;
    case (state)
      IDLE: begin
        if (start && !abort) begin
          addr_next      = base_addr;
          remaining_next = pix_count;
          state_next     = (pix_count == '0) ? DONE : REQ;
        end
      end
      REQ: state_next = WAIT;
      WAIT: begin
        if (rd_valid) begin
          m_data_next  = {ALPHA, lane_f16[2], lane_f16[1], lane_f16[0]};
          m_valid_next = 1'b1;
          m_last_next  = (remaining == CNT_W'(1));
          state_next   = EMIT;
        end
      end
      EMIT: begin
        // Only one read is ever outstanding, so no next word can be ready on accept.
        if (m_ready) begin
          m_valid_next   = 1'b0;
          m_last_next    = 1'b0;
          addr_next      = addr + ADDR_W'(ADDR_INC);
          remaining_next = remaining - CNT_W'(1);
          state_next     = (remaining == CNT_W'(1)) ? DONE : REQ;
        end
      end
      DONE: begin
        done_next  = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    if (abort && state != IDLE) begin
      state_next   = IDLE;
      m_valid_next = 1'b0;
      m_last_next  = 1'b0;
      done_next    = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      addr      <= '0;
      remaining <= '0;
      m_valid   <= 1'b0;
      m_data    <= '0;
      m_last    <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_next;
      addr      <= addr_next;
      remaining <= remaining_next;
      m_valid   <= m_valid_next;
      m_data    <= m_data_next;
      m_last    <= m_last_next;
      done      <= done_next;
    end
  end

endmodule

// File: tb/tb_rgb_f16_frame_sequencer.sv
// Randomized self-checking bench for rgb_f16_frame_sequencer against an arithmetic FP16 reference model.
// Honours F16_ALPHA_ONE_EN for the expected alpha lane.
module tb_rgb_f16_frame_sequencer;

`ifdef F16_ALPHA_ONE_EN
  localparam logic [15:0] ALPHA = 16'h3C00;
`else
  localparam logic [15:0] ALPHA = 16'h0000;
`endif

  logic        clk = 1'b0;
  logic        rst, start, abort, rd_valid, m_ready;
  logic [31:0] base_addr, rd_data, rd_addr;
  logic [19:0] pix_count;
  logic        rd_req, m_valid, m_last, busy, done;
  logic [63:0] m_data;

  int n_cmp = 0;
  int n_bad = 0;

  rgb_f16_frame_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .base_addr(base_addr), .pix_count(pix_count),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_valid(rd_valid), .rd_data(rd_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // FP16 value of an integer 1..255 is 2^p * (1 + frac): exponent field 15+p, fraction scaled to 10 bits.
  function automatic logic [15:0] ref_f16(input int u);
    int p;
    int v;
    if (u == 0) return 16'h0000;
    p = 0;
    while ((u >> (p + 1)) != 0) p++;
    v = (15 + p) * 1024 + (u - (1 << p)) * (1 << (10 - p));
    return 16'(v);
  endfunction

  function automatic logic [63:0] ref_word(input logic [31:0] d);
    return {ALPHA, ref_f16(int'(d[23:16])), ref_f16(int'(d[15:8])), ref_f16(int'(d[7:0]))};
  endfunction

  task automatic check_idle_outputs(input string tag);
    check({tag, "_rd_req"}, rd_req, 0);
    check({tag, "_rd_addr"}, rd_addr, 0);
    check({tag, "_m_valid"}, m_valid, 0);
    check({tag, "_m_data"}, m_data, 0);
    check({tag, "_m_last"}, m_last, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
  endtask

  // mode: 0 random data, 1 lane sweep by pixel index, 2 fixed word.
  task automatic run_frame(input logic [31:0] base, input int count, input int mode,
                           input logic [31:0] fixed, input int ready_pct,
                           input int abort_at, input int rst_at);
    logic [63:0] exp_q[$];
    logic [63:0] held;
    logic [31:0] pdata, ea;
    int issued = 0, accepted = 0, pend = 0, lat = 0, dones = 0, done_cyc = -1;
    int cyc = 0, post_abort = 0;
    bit aborted = 0, finished = 0, stall_prev = 0, seen_valid = 0, did_rst = 0;
    held = '0;
    pdata = '0;
    @(negedge clk);
    base_addr = base;
    pix_count = count[19:0];
    start = 1'b1;
    while (!finished && cyc < 20000) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      abort = 1'b0;
      rd_valid = 1'b0;
      rd_data = $urandom;
      if (cyc == 3 && count >= 2 && abort_at < 0 && rst_at < 0) begin
        start = 1'b1;
        base_addr = $urandom;
        pix_count = 20'($urandom);
      end
      if (done) begin
        dones++;
        done_cyc = cyc;
        check("busy_with_done", busy, 0);
        finished = 1;
      end
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          rd_valid = 1'b1;
          rd_data = pdata;
          if (!aborted) exp_q.push_back(ref_word(pdata));
        end
      end
      if (aborted) begin
        check("abort_rd_req", rd_req, 0);
        check("abort_m_valid", m_valid, 0);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        post_abort++;
        if (post_abort >= 5) finished = 1;
      end else if (rst_at >= 0 && m_valid && accepted == rst_at) begin
        m_ready = 1'b0;
        #1 rst = 1'b1;
        #1 check_idle_outputs("rst_mid");
        did_rst = 1;
        finished = 1;
      end else begin
        if (rd_req) begin
          ea = base + 32'(issued * 4);
          check("rd_addr", rd_addr, ea);
          check("one_outstanding", pend, 0);
          lat = (abort_at >= 0 && issued == abort_at) ? 3 : $urandom_range(1, 4);
          pend = lat;
          case (mode)
            1: pdata = {8'($urandom), 8'(issued), 8'(issued + 85), 8'(issued + 170)};
            2: pdata = fixed;
            default: pdata = $urandom;
          endcase
          issued++;
        end
        if (m_valid) begin
          seen_valid = 1;
          if (stall_prev) check("stall_data", m_data, held);
          else if (exp_q.size() == 0) check("m_valid_spurious", 1, 0);
          else begin
            check("m_data", m_data, exp_q[0]);
            check("m_last", m_last, (accepted == count - 1));
          end
          held = m_data;
          m_ready = ($urandom_range(0, 99) < ready_pct);
          if (m_ready) begin
            accepted++;
            if (exp_q.size() != 0) void'(exp_q.pop_front());
            stall_prev = 0;
          end else stall_prev = 1;
        end else begin
          if (stall_prev) check("stall_valid", m_valid, 1);
          stall_prev = 0;
          m_ready = 1'($urandom_range(0, 1));
        end
        if (abort_at >= 0 && !aborted && issued == abort_at + 1 && pend == 2) begin
          abort = 1'b1;
          aborted = 1;
        end
      end
    end
    if (cyc >= 20000) check("frame_timeout", 1, 0);
    if (did_rst) begin
      @(negedge clk);
      rst = 1'b0;
      check_idle_outputs("rst_release");
    end else if (aborted) begin
      check("abort_no_done", dones, 0);
    end else begin
      check("accepts", accepted, count);
      check("reads", issued, count);
      check("done_count", dones, 1);
      if (count == 0) begin
        check("zero_done_cycle", done_cyc, 2);
        check("zero_no_valid", seen_valid, 0);
      end
    end
    start = 1'b0;
    abort = 1'b0;
    rd_valid = 1'b0;
    $display("frame base=%h count=%0d reads=%0d accepts=%0d dones=%0d abort=%0d rst=%0d",
             base, count, issued, accepted, dones, aborted, did_rst);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; rd_valid = 1'b0; m_ready = 1'b0;
    base_addr = '0; pix_count = '0; rd_data = '0;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    rst = 1'b0;
    @(negedge clk);
    check_idle_outputs("post_reset");

    run_frame(32'h0000_0100, 1, 2, 32'h00FF_8001, 100, -1, -1);
    run_frame(32'h0000_0200, 4, 0, 32'h0, 50, -1, -1);
    run_frame(32'h0000_0300, 0, 0, 32'h0, 50, -1, -1);

    // start and abort together in IDLE: abort wins
    @(negedge clk);
    base_addr = 32'h0000_0800; pix_count = 20'd5; start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("start_abort_busy", busy, 0);
      check("start_abort_rd_req", rd_req, 0);
      @(negedge clk);
    end

    run_frame(32'h0000_1000, 256, 1, 32'h0, 70, -1, -1);
    run_frame(32'hFFFF_FFF8, 3, 0, 32'h0, 60, -1, -1);
    run_frame(32'h0000_0400, 8, 0, 32'h0, 80, 3, -1);
    run_frame(32'h0000_0500, 2, 0, 32'h0, 50, -1, -1);
    run_frame(32'h0000_0600, 8, 0, 32'h0, 50, -1, 2);
    run_frame(32'h0000_0700, 3, 0, 32'h0, 50, -1, -1);
    for (int f = 0; f < 6; f++) begin
      run_frame($urandom & 32'hFFFF_FFFC, $urandom_range(1, 20), 0, 32'h0,
                $urandom_range(30, 100), -1, -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
